// File: rtl/accel_csr_q.sv
// Accelerator CSR block: tile configuration registers, a snapshot job queue
// popped by the core over valid/ready, a maskable IRQ controller and result capture.
module accel_csr_q #(
  parameter int ADDR_W    = 8,
  parameter int QDEPTH    = 4,
  parameter int N_RESULT  = 4,
  parameter int N_EXT_IRQ = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    csr_wen,
  input  logic                    csr_ren,
  input  logic [ADDR_W-1:0]       csr_addr,
  input  logic [31:0]             csr_wdata,
  output logic [31:0]             csr_rdata,
  input  logic                    core_busy,
  input  logic                    core_done_tile_pulse,
  input  logic [32*N_RESULT-1:0]  result_data,
  input  logic [N_EXT_IRQ-1:0]    ext_irq,
  output logic                    job_valid,
  input  logic                    job_ready,
  output logic [191:0]            job_cfg,
  output logic                    abort_pulse,
  output logic                    irq
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int IW = 3 + N_EXT_IRQ;
  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_QSTAT = ADDR_W'(32'h1C);
  localparam logic [ADDR_W-1:0] A_IST   = ADDR_W'(32'h20);
  localparam logic [ADDR_W-1:0] A_IEN   = ADDR_W'(32'h24);

  // cfg_q index: 0=M 1=N 2=K 3=Tm 4=Tn 5=Tk
  logic [31:0]   cfg_q    [6];
  logic [191:0]  mem_q    [QDEPTH];
  logic [31:0]   result_q [N_RESULT];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] irq_stat_q, irq_stat_d, irq_en_q, irq_en_d, ev, w1c;
  logic          job_valid_q, irq_q;
  logic [191:0]  job_cfg_q, head_d, snap;
  logic          ctrl_wr, abort_req, push_req, push_ok, pop, drained;
  logic          unused_ok;

  assign unused_ok = csr_ren ^ core_busy;

  // Handshake: a job transfers on every rising clk edge where job_valid && job_ready;
  // job_cfg holds while job_valid is high and job_ready is low.
  assign ctrl_wr   = csr_wen && (csr_addr == A_CTRL);
  assign abort_req = ctrl_wr && csr_wdata[1];
  assign push_req  = ctrl_wr && csr_wdata[0] && !csr_wdata[1];
  assign push_ok   = push_req && (count_q != CW'(QDEPTH)) &&
                     (cfg_q[3] != '0) && (cfg_q[4] != '0) && (cfg_q[5] != '0);
  assign pop       = job_valid_q && job_ready && !abort_req;
  assign drained   = pop && !push_ok && (count_q == CW'(1));
  assign snap      = {cfg_q[5], cfg_q[4], cfg_q[3], cfg_q[2], cfg_q[1], cfg_q[0]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push_ok) count_d = count_q - CW'(1);
    end
    // The entry being written this edge is not in mem_q yet, so bypass it to the head.
    head_d = mem_q[rd_ptr_d];
    if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = snap;
  end

  always_comb begin
    ev                 = '0;
    ev[0]              = core_done_tile_pulse;
    ev[1]              = drained;
    ev[2]              = push_req && !push_ok;
    ev[3 +: N_EXT_IRQ] = ext_irq;
    w1c        = (csr_wen && csr_addr == A_IST) ? csr_wdata[IW-1:0] : '0;
    irq_stat_d = (irq_stat_q & ~w1c) | ev;
    irq_en_d   = (csr_wen && csr_addr == A_IEN) ? csr_wdata[IW-1:0] : irq_en_q;
  end

  always_comb begin
    csr_rdata = 32'hDEADBEEF;
    case (csr_addr)
      A_CTRL:  csr_rdata = 32'h0;
      A_QSTAT: csr_rdata = {22'd0, count_q == '0, count_q == CW'(QDEPTH), 3'd0, 5'(count_q)};
      A_IST:   csr_rdata = 32'(irq_stat_q);
      A_IEN:   csr_rdata = 32'(irq_en_q);
      default: csr_rdata = 32'hDEADBEEF;
    endcase
    for (int i = 0; i < 6; i++)
      if (csr_addr == ADDR_W'(4 + 4 * i)) csr_rdata = cfg_q[i];
    for (int i = 0; i < N_RESULT; i++)
      if (csr_addr == ADDR_W'(128 + 4 * i)) csr_rdata = result_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++)        cfg_q[i]    <= '0;
      for (int i = 0; i < QDEPTH; i++)   mem_q[i]    <= '0;
      for (int i = 0; i < N_RESULT; i++) result_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      irq_stat_q  <= '0;
      irq_en_q    <= '0;
      job_valid_q <= 1'b0;
      job_cfg_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (csr_wen && csr_addr == ADDR_W'(4 + 4 * i)) cfg_q[i] <= csr_wdata;
      if (push_ok) mem_q[wr_ptr_q] <= snap;
      if (core_done_tile_pulse)
        for (int i = 0; i < N_RESULT; i++) result_q[i] <= result_data[32*i +: 32];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      irq_stat_q  <= irq_stat_d;
      irq_en_q    <= irq_en_d;
      job_valid_q <= (count_d != '0);
      job_cfg_q   <= (count_d != '0) ? head_d : '0;
      irq_q       <= |(irq_stat_d & irq_en_d);
    end
  end

  assign job_valid   = job_valid_q;
  assign job_cfg     = job_cfg_q;
  assign irq         = irq_q;
  assign abort_pulse = abort_req;
endmodule

// File: tb/tb_accel_csr_q.sv
// Bench for accel_csr_q: reset vector table, directed multi-cycle sequences,
// then randomized traffic compared with a queue-based reference model.
module tb_accel_csr_q;
  localparam int QD = 4;
  localparam int NR = 4;
  localparam int NE = 2;
  localparam int IW = 3 + NE;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           csr_wen = 1'b0, csr_ren = 1'b0;
  logic [7:0]     csr_addr = '0;
  logic [31:0]    csr_wdata = '0, csr_rdata;
  logic           core_busy = 1'b0, core_done = 1'b0;
  logic [32*NR-1:0] result_data = '0;
  logic [NE-1:0]  ext_irq = '0;
  logic           job_valid, job_ready = 1'b0, abort_pulse, irq;
  logic [191:0]   job_cfg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [191:0]  mq[$];
  logic [31:0]   m_cfg [6];
  logic [31:0]   m_res [NR];
  logic [IW-1:0] m_stat, m_en;
  logic          m_irq;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t rst_tab [8];

  accel_csr_q #(.ADDR_W(8), .QDEPTH(QD), .N_RESULT(NR), .N_EXT_IRQ(NE)) dut (
    .clk(clk), .rst_n(rst_n), .csr_wen(csr_wen), .csr_ren(csr_ren),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .core_busy(core_busy), .core_done_tile_pulse(core_done), .result_data(result_data),
    .ext_irq(ext_irq), .job_valid(job_valid), .job_ready(job_ready), .job_cfg(job_cfg),
    .abort_pulse(abort_pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(name, {160'd0, csr_rdata}, {160'd0, exp});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_wen = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_wen = 1'b0;
  endtask

  function automatic logic [31:0] exp_qstat(input int n);
    return (n == 0 ? 32'h200 : 32'h0) | (n == QD ? 32'h100 : 32'h0) | 32'(n);
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 6; i++) m_cfg[i] = '0;
    for (int i = 0; i < NR; i++) m_res[i] = '0;
    m_stat = '0; m_en = '0; m_irq = 1'b0;
  endtask

  // Applies one clock edge worth of the register-map rules to the model.
  task automatic model_step();
    int n0;
    bit ctrl, ab, pr, legal, pp;
    logic [IW-1:0] ev, w1c;
    n0 = mq.size();
    ctrl  = csr_wen && csr_addr == 8'h00;
    ab    = ctrl && csr_wdata[1];
    pr    = ctrl && csr_wdata[0] && !csr_wdata[1];
    legal = pr && n0 < QD && m_cfg[3] != 0 && m_cfg[4] != 0 && m_cfg[5] != 0;
    pp    = n0 > 0 && job_ready;
    ev = '0; w1c = '0;
    if (ab) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (legal) mq.push_back({m_cfg[5], m_cfg[4], m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
      if (pp && mq.size() == 0) ev[1] = 1'b1;
    end
    if (pr && !legal) ev[2] = 1'b1;
    if (core_done) begin
      ev[0] = 1'b1;
      for (int i = 0; i < NR; i++) m_res[i] = result_data[32*i +: 32];
    end
    ev[3 +: NE] = ext_irq;
    if (csr_wen && csr_addr >= 8'h04 && csr_addr <= 8'h18 && csr_addr[1:0] == 2'b00)
      m_cfg[(csr_addr - 8'h04) >> 2] = csr_wdata;
    if (csr_wen && csr_addr == 8'h20) w1c = csr_wdata[IW-1:0];
    if (csr_wen && csr_addr == 8'h24) m_en = csr_wdata[IW-1:0];
    m_stat = (m_stat & ~w1c) | ev;
    m_irq  = |(m_stat & m_en);
  endtask

  initial begin
    rst_tab[0] = '{8'h24, 32'h0};
    rst_tab[1] = '{8'h1C, 32'h200};
    rst_tab[2] = '{8'h44, 32'hDEADBEEF};
    rst_tab[3] = '{8'h00, 32'h0};
    rst_tab[4] = '{8'h04, 32'h0};
    rst_tab[5] = '{8'h20, 32'h0};
    rst_tab[6] = '{8'h80, 32'h0};
    rst_tab[7] = '{8'h90, 32'hDEADBEEF};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk_rd($sformatf("reset_rd_%0d", i), rst_tab[i].addr, rst_tab[i].exp);
    chk("reset_job_valid", {191'd0, job_valid}, 192'd0);
    chk("reset_irq", {191'd0, irq}, 192'd0);
    chk("reset_job_cfg", job_cfg, 192'd0);
    chk("reset_abort", {191'd0, abort_pulse}, 192'd0);

    // Single job: push, observe head, pop, drained interrupt
    wr(8'h04, 8); wr(8'h08, 8); wr(8'h0C, 8);
    wr(8'h10, 2); wr(8'h14, 2); wr(8'h18, 2);
    wr(8'h00, 1);
    chk("push1_valid", {191'd0, job_valid}, 192'd1);
    chk("push1_cfg", job_cfg, {32'd2, 32'd2, 32'd2, 32'd8, 32'd8, 32'd8});
    chk_rd("push1_qstat", 8'h1C, 32'h1);
    @(negedge clk);
    job_ready = 1'b1;
    @(negedge clk);
    job_ready = 1'b0;
    chk_rd("pop1_qstat", 8'h1C, 32'h200);
    chk_rd("pop1_drained", 8'h20, 32'h2);
    chk("pop1_valid", {191'd0, job_valid}, 192'd0);

    // Overfill then drain in order
    wr(8'h20, 32'h1F);
    for (int i = 0; i < 5; i++) begin
      wr(8'h04, 100 + i);
      wr(8'h00, 1);
    end
    chk_rd("full_qstat", 8'h1C, 32'h104);
    chk_rd("full_err", 8'h20, 32'h4);
    @(negedge clk);
    job_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order_valid_%0d", i), {191'd0, job_valid}, 192'd1);
      chk($sformatf("order_m_%0d", i), {160'd0, job_cfg[31:0]}, 192'(100 + i));
      @(negedge clk);
    end
    job_ready = 1'b0;
    chk_rd("drain_qstat", 8'h1C, 32'h200);
    chk_rd("drain_stat", 8'h20, 32'h6);

    // Zero tile size rejects the push; irq follows enable and clear
    wr(8'h20, 32'h1F);
    wr(8'h10, 0);
    wr(8'h00, 1);
    chk_rd("tm0_qstat", 8'h1C, 32'h200);
    chk_rd("tm0_err", 8'h20, 32'h4);
    chk("tm0_irq_masked", {191'd0, irq}, 192'd0);
    wr(8'h24, 4);
    chk("irq_rise", {191'd0, irq}, 192'd1);
    wr(8'h20, 4);
    chk("irq_fall", {191'd0, irq}, 192'd0);

    // Result capture and set-beats-clear
    @(negedge clk);
    result_data = {32'd4, 32'd3, 32'd2, 32'd1};
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    for (int i = 0; i < 4; i++) chk_rd($sformatf("result_%0d", i), 8'(128 + 4 * i), 32'(i + 1));
    chk_rd("done_stat", 8'h20, 32'h1);
    @(negedge clk);
    core_done = 1'b1;
    csr_wen = 1'b1; csr_addr = 8'h20; csr_wdata = 32'h1;
    @(negedge clk);
    core_done = 1'b0; csr_wen = 1'b0;
    chk_rd("set_wins", 8'h20, 32'h1);

    // Abort with push in the same write
    wr(8'h10, 2);
    for (int i = 0; i < 3; i++) wr(8'h00, 1);
    chk_rd("pre_abort_qstat", 8'h1C, 32'h3);
    wr(8'h20, 32'h1F);
    @(negedge clk);
    csr_wen = 1'b1; csr_addr = 8'h00; csr_wdata = 32'h3;
    #1 chk("abort_high", {191'd0, abort_pulse}, 192'd1);
    @(negedge clk);
    csr_wen = 1'b0;
    #1 chk("abort_low", {191'd0, abort_pulse}, 192'd0);
    chk("abort_valid", {191'd0, job_valid}, 192'd0);
    chk_rd("abort_qstat", 8'h1C, 32'h200);
    chk_rd("abort_stat", 8'h20, 32'h0);

    // Asynchronous reset mid-operation
    wr(8'h00, 1);
    wr(8'h00, 1);
    chk("prerst_valid", {191'd0, job_valid}, 192'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_valid", {191'd0, job_valid}, 192'd0);
    chk_rd("midrst_qstat", 8'h1C, 32'h200);
    chk_rd("midrst_tm", 8'h10, 32'h0);
    chk_rd("midrst_res", 8'h80, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      int r, idx;
      @(negedge clk);
      csr_wen = 1'b0; job_ready = 1'b0; core_done = 1'b0; ext_irq = '0;
      chk("rnd_valid", {191'd0, job_valid}, {191'd0, mq.size() != 0});
      if (mq.size() != 0) chk("rnd_cfg", job_cfg, mq[0]);
      chk("rnd_irq", {191'd0, irq}, {191'd0, m_irq});
      chk_rd("rnd_qstat", 8'h1C, exp_qstat(mq.size()));
      chk_rd("rnd_stat", 8'h20, 32'(m_stat));
      idx = $urandom_range(0, NR - 1);
      chk_rd("rnd_result", 8'(128 + 4 * idx), m_res[idx]);

      r = $urandom_range(0, 99);
      csr_addr = 8'h00; csr_wdata = '0;
      if (r < 30) begin
        csr_wen = 1'b1; csr_wdata = 32'h1;
      end else if (r < 33) begin
        csr_wen = 1'b1; csr_wdata = $urandom_range(2, 3);
      end else if (r < 55) begin
        csr_wen = 1'b1;
        csr_addr = 8'(4 + 4 * $urandom_range(0, 5));
        csr_wdata = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      end else if (r < 62) begin
        csr_wen = 1'b1; csr_addr = 8'h20; csr_wdata = $urandom;
      end else if (r < 66) begin
        csr_wen = 1'b1; csr_addr = 8'h24; csr_wdata = $urandom;
      end else if (r < 70) begin
        csr_wen = 1'b1; csr_wdata = $urandom;
        csr_addr = ($urandom_range(0, 1) == 0) ? 8'h1C : 8'h84;
      end
      job_ready = ($urandom_range(0, 2) == 0);
      core_done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) ext_irq = NE'($urandom);
      result_data = {$urandom, $urandom, $urandom, $urandom};
      csr_ren = $urandom_range(0, 1);
      #1 chk("rnd_abort", {191'd0, abort_pulse},
             {191'd0, csr_wen && csr_addr == 8'h00 && csr_wdata[1]});
      model_step();
    end
    @(negedge clk);
    csr_wen = 1'b0; job_ready = 1'b0; core_done = 1'b0; ext_irq = '0;
    chk("final_valid", {191'd0, job_valid}, {191'd0, mq.size() != 0});
    chk_rd("final_qstat", 8'h1C, exp_qstat(mq.size()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/accel_csr_q.md
Name: accel_csr_q

Overview:
- Next-generation control/status register block for the accelerator, driven by the UART bridge or AXI-lite shim.
- Adds a QDEPTH-entry job queue: each host "push" snapshots the current tile configuration, and the core pops jobs through a valid/ready handshake.
- Adds a maskable, parametrised interrupt controller (status/enable, level IRQ) and a parametrised bank of result capture registers.

Parameters:
ADDR_W, 8, byte-address width; 0x80+4*N_RESULT must be ≤ 2^ADDR_W
QDEPTH, 4, job queue depth (power of 2, 2..16)
N_RESULT, 4, number of 32-bit result capture registers
N_EXT_IRQ, 2, external interrupt sources mapped to IRQ bits [3 +: N_EXT_IRQ]

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
csr_wen  in  1  write strobe
csr_ren  in  1  read strobe (informational; reads are side-effect free)
csr_addr  in  ADDR_W  byte address, word aligned
csr_wdata  in  32  write data
csr_rdata  out  32  combinational read data
core_busy  in  1  core executing a job
core_done_tile_pulse  in  1  one-cycle job-complete pulse
result_data  in  32*N_RESULT  results; word i = bits [32i +: 32]
ext_irq  in  N_EXT_IRQ  external event pulses
job_valid  out  1  queue head valid
job_ready  in  1  core accepts head
job_cfg  out  192  head snapshot {Tk,Tn,Tm,K,N,M}; M in [31:0]
abort_pulse  out  1  one-cycle abort to core
irq  out  1  registered level interrupt

Behaviour:
- Reset is asynchronous, active-low rst_n; clock clk. Reset values:
  - all config, result and IRQ registers 0; queue empty.
  - job_valid=0, job_cfg=0, abort_pulse=0, irq=0.
- Address map:
  - 0x00 CTRL: [0]=push (W1P), [1]=abort (W1P); reads 0.
  - 0x04..0x18: M, N, K, Tm, Tn, Tk (RW).
  - 0x1C QSTAT (RO): [4:0]=count, [8]=full, [9]=empty.
  - 0x20 IRQ_STATUS: R/W1C, width 3+N_EXT_IRQ.
  - 0x24 IRQ_EN: RW, same width.
  - 0x80+4i RESULT_i (RO).
  - Any other address reads 0xDEADBEEF; writes to it are ignored.
- IRQ_STATUS bits:
  - bit0: done_tile.
  - bit1: queue drained (count goes 1→0 by a pop).
  - bit2: push error.
  - bits 3+: ext_irq[j].
- Push (CTRL write with wdata[0]=1, abort not also set):
  - Legal when the queue is not full AND Tm, Tn and Tk are all nonzero.
  - Legal push: enqueue {Tk,Tn,Tm,K,N,M} as the register values *before* this cycle's write. A config write in the same cycle is impossible, because the bus is single-access.
  - Illegal push: drop the job and set IRQ bit2.
- Full is evaluated from the count at the start of the cycle. A push while full is rejected even if a pop occurs in the same cycle.
- Pop: occurs when job_valid && job_ready; the head advances on that clock edge.
- job_valid and job_cfg are registered:
  - A push into an empty queue shows job_valid=1 on the cycle after the write.
  - job_cfg is stable while job_valid=1 and job_ready=0.
- Simultaneous push and pop with 0<count<QDEPTH: count is unchanged and ordering is preserved.
- Abort (wdata[1]=1):
  - abort_pulse=1 for exactly that cycle.
  - The queue is flushed on that edge (count=0, job_valid=0 next cycle).
  - A push or pop in the same cycle is discarded; no error and no drained IRQ.
- Result capture: on core_done_tile_pulse, latch all N_RESULT words and set IRQ bit0.
- IRQ status updates:
  - A source event and a W1C of the same bit in the same cycle: set wins.
  - Writing 0 to a bit has no effect.
- irq is a registered output: irq <= |(IRQ_STATUS_next & IRQ_EN). It rises one cycle after the event and falls one cycle after the clear or mask.
- Count is ⌈log2(QDEPTH+1)⌉ bits, zero-extended into QSTAT[4:0]. Pointers wrap modulo QDEPTH.
- Reset asserted mid-operation: immediate return to reset values, with the queue contents lost.

Test Plan:
- After reset: read 0x24 → 0. Read 0x1C → 0x200 (empty). Read 0x44 → 0xDEADBEEF. irq=0, job_valid=0.
- Write M=8, N=8, K=8, Tm=Tn=Tk=2, then push, with job_ready=0:
  - job_valid=1 next cycle, job_cfg = {2,2,2,8,8,8}, QSTAT count=1.
  - Raise job_ready for one cycle → count=0, IRQ_STATUS bit1=1.
- Push 5 times with job_ready=0 (QDEPTH=4): QSTAT=0x104 (count 4, full), IRQ bit2=1. Then pop 4 → jobs emerge in push order with the values written between pushes.
- Tm=0 then push → no enqueue, IRQ bit2=1. Set IRQ_EN=0x4 → irq=1 one cycle later. Write 0x20=0x4 → irq=0 one cycle after.
- result_data = {0x4,0x3,0x2,0x1} with a done pulse → RESULT_0..3 read 1,2,3,4, IRQ bit0=1. A done pulse coincident with a W1C of bit0 → bit0 stays 1.
- With 3 jobs queued, write CTRL=0x3 (push+abort): abort_pulse high for 1 cycle, count=0, job_valid=0, IRQ bits 1 and 2 stay 0.
